joy_move_sequencer: RTL
=======================

Name: joy_move_sequencer

Overview:
- Sequences joystick ADC sampling and turns raw 13-bit voltage samples into debounced, auto-repeating move commands for game logic.
- Requests one conversion per sample interval and classifies each sample using the board's fixed direction thresholds.
- Filters the result over several consecutive samples, then emits single-cycle move pulses: one on press, then repeats while held.
- Sits between the ADC interface and the game-state FSM (board movement in play mode, left/right selection in pick mode).

Parameters:
SAMPLE_INTERVAL, 50000, idle cycles between end of one sample evaluation and next request (1 ms @ 50 MHz)
DEBOUNCE_CNT, 4, consecutive identical classified samples required to accept a code (>=1)
REPEAT_DELAY, 20, held samples after first pulse before first auto-repeat (>=1)
REPEAT_PERIOD, 5, held samples between subsequent auto-repeats (>=1)
TIMEOUT, 1000, max cycles waiting for adc_valid (used only with optional feature)

Ports:
sys_clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
pickMode  in  1  0 = play mode (4 directions), 1 = pick mode (left/right)
adc_req  out  1  single-cycle conversion request
adc_valid  in  1  conversion result valid, single cycle
adc_data  in  13  conversion result (vol)
move_pulse  out  1  one-cycle strobe, play-mode move
move_dir  out  3  accepted play-mode code: 0 none, 1..4
lr_pulse  out  1  one-cycle strobe, pick-mode move
lr_dir  out  3  accepted pick-mode code: 0 none, 1, 2
adc_err  out  1  sticky timeout flag (optional feature only; else tied 0)

Behaviour:
- Interface: one clock, sys_clk; Reset is synchronous and active-high.
- Reset: state S_REQ. All outputs 0. All counters, candidate, accepted code and stored mode are 0. Applying Reset mid-conversion aborts the conversion; a late adc_valid is ignored.
- FSM S_REQ -> S_WAIT -> S_EVAL -> S_GAP -> S_REQ:
  - S_REQ: adc_req=1 for exactly one cycle.
  - S_WAIT: on adc_valid=1, capture adc_data and go to S_EVAL. adc_valid in any other state, including the S_REQ cycle, is ignored.
  - S_EVAL: one cycle. Classify, update debounce and repeat, register pulses.
  - S_GAP: load counter with SAMPLE_INTERVAL-1 and count down; at 0 go to S_REQ.
- Classification (unsigned, inclusive bounds):
  - play: 2000..3000 -> 1; 150..1000 -> 2; <150 -> 3; >3000 -> 4; else 0.
  - pick: 2000..3000 -> 1; >3000 -> 2; else 0.
- Mode change: if pickMode in S_EVAL differs from the stored mode:
  - store the new mode; clear candidate, stable count, accepted code, both dir outputs and repeat count;
  - no pulse this sample; the new sample seeds the candidate with stable=1.
- Debounce:
  - new==cand: stable saturates at DEBOUNCE_CNT.
  - new!=cand: cand=new, stable=1.
  - Acceptance occurs on the sample where stable reaches DEBOUNCE_CNT.
- Pulse and repeat, per sample:
  - Newly accepted nonzero code: pulse; rep=REPEAT_DELAY.
  - Accepted code still held and nonzero: rep decrements; on reaching 0, pulse and rep=REPEAT_PERIOD.
  - Accepted code becomes 0 (released): no pulse, rep=0.
  - A different nonzero code must be re-accepted, which gives an immediate pulse.
- Outputs:
  - Pulse goes high the cycle after S_EVAL, for exactly 1 cycle.
  - move_pulse is used in play mode only, lr_pulse in pick mode only; the two are never high together.
  - move_dir/lr_dir are registered, update with the pulse, and hold between pulses. Each is 0 while its mode is inactive.
  - Pulse-to-pulse spacing is measured in samples, not cycles.

Optional Feature:
ADC_TIMEOUT_EN
- Defined: S_WAIT counts cycles. After TIMEOUT cycles without adc_valid:
  - adc_err=1 (sticky until Reset);
  - sample treated as code 0;
  - proceed to S_EVAL.
- Undefined: S_WAIT waits indefinitely; adc_err is constant 0; no timeout counter is synthesized.

Test Plan:
- Params SAMPLE_INTERVAL=4, DEBOUNCE_CNT=3, REPEAT_DELAY=4, REPEAT_PERIOD=2. pickMode=0, constant adc_data=2500 -> first move_pulse on 3rd sample, move_dir=1; next pulses on samples 7, 9, 11.
- pickMode=0, samples 140,140,500,140,140,140 -> no pulse until 6th sample; then move_pulse with move_dir=3. Verify adc_data=150 classifies as 2 and 1001 as 0.
- pickMode=1, adc_data=3001 held -> lr_pulse with lr_dir=2 on 3rd sample; move_pulse stays 0. Toggle pickMode to 0 mid-hold -> no pulse on the toggle sample; lr_dir=0; play-mode acceptance restarts.
- Hold 2500 until the first pulse, then 0 for 3 samples, then 2500 -> fresh pulse 3 samples later (no repeat carry-over). adc_valid pulsed during S_GAP -> ignored.
- Assert Reset while in S_WAIT; adc_valid arrives 2 cycles later -> ignored; outputs 0; adc_req reasserted in the first cycle after Reset deasserts.
- With ADC_TIMEOUT_EN and TIMEOUT=10, never drive adc_valid -> adc_err=1 at cycle 10 of S_WAIT; FSM continues; no pulses.

Source files
------------

// File: rtl/joy_move_sequencer.sv
// Joystick ADC sequencer: periodic sampling, threshold classification, debounce and auto-repeat.
// Optional ADC_TIMEOUT_EN adds a bounded wait for adc_valid with a sticky adc_err flag.
module joy_move_sequencer #(
  parameter int SAMPLE_INTERVAL = 50000,
  parameter int DEBOUNCE_CNT    = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 5,
  parameter int TIMEOUT         = 1000
) (
  input  logic        sys_clk,
  input  logic        Reset,
  input  logic        pickMode,
  output logic        adc_req,
  input  logic        adc_valid,
  input  logic [12:0] adc_data,
  output logic        move_pulse,
  output logic [2:0]  move_dir,
  output logic        lr_pulse,
  output logic [2:0]  lr_dir,
  output logic        adc_err
);

  localparam int GAP_W = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W = $clog2(REP_MAX + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CNT);

  if (SAMPLE_INTERVAL < 1 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 ||
      REPEAT_PERIOD < 1 || TIMEOUT < 1) begin : g_param_check
    $error("joy_move_sequencer: all parameters must be >= 1");
  end

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_EVAL, S_GAP} state_t;

  state_t            state, state_n;
  logic [GAP_W-1:0]  gap_cnt;
  logic [12:0]       sample;
  logic              sample_zero;
  logic              mode_q;
  logic [2:0]        cand, accepted;
  logic [DB_W-1:0]   stable;
  logic [REP_W-1:0]  rep;
  logic              wait_expired;

  function automatic logic [2:0] classify(input logic [12:0] v, input logic pick);
    logic [2:0] c;
    c = 3'd0;
    if (v >= 13'd2000 && v <= 13'd3000) c = 3'd1;
    else if (pick)                      c = (v > 13'd3000) ? 3'd2 : 3'd0;
    else if (v >= 13'd150 && v <= 13'd1000) c = 3'd2;
    else if (v < 13'd150)               c = 3'd3;
    else if (v > 13'd3000)              c = 3'd4;
    return c;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    case (state)
      S_REQ:   state_n = S_WAIT;
      S_WAIT:  if (adc_valid || wait_expired) state_n = S_EVAL;
      S_EVAL:  state_n = S_GAP;
      S_GAP:   if (gap_cnt == '0) state_n = S_REQ;
      default: state_n = S_REQ;
    endcase
  end

  // Held low during Reset so every output reads 0 while reset is applied.
  assign adc_req = (state == S_REQ) && !Reset;

  // Per-sample evaluation: debounce, acceptance and repeat scheduling.
  logic [2:0]       code_new, acc_n;
  logic [DB_W-1:0]  stable_n;
  logic [REP_W-1:0] rep_n;
  logic             mode_chg, same, reach, pulse;

  always_comb begin
    code_new = sample_zero ? 3'd0 : classify(sample, pickMode);
    mode_chg = (pickMode != mode_q);
    same     = (code_new == cand);
    stable_n = same ? ((stable == DB_MAX) ? DB_MAX : stable + 1'b1) : DB_W'(1);
    reach    = (stable_n == DB_MAX) && (!same || stable != DB_MAX);
    acc_n    = accepted;
    rep_n    = rep;
    pulse    = 1'b0;
    if (reach) begin
      acc_n = code_new;
      if (code_new != 3'd0) begin
        pulse = 1'b1;
        rep_n = REP_W'(REPEAT_DELAY);
      end else begin
        rep_n = '0;
      end
    end else if (accepted != 3'd0) begin
      if (rep <= REP_W'(1)) begin
        pulse = 1'b1;
        rep_n = REP_W'(REPEAT_PERIOD);
      end else begin
        rep_n = rep - 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (Reset) state <= S_REQ;
    else       state <= state_n;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (Reset) begin
      gap_cnt     <= '0;
      sample      <= '0;
      sample_zero <= 1'b0;
      mode_q      <= 1'b0;
      cand        <= '0;
      stable      <= '0;
      accepted    <= '0;
      rep         <= '0;
      move_pulse  <= 1'b0;
      lr_pulse    <= 1'b0;
      move_dir    <= '0;
      lr_dir      <= '0;
    end else begin
      move_pulse <= 1'b0;
      lr_pulse   <= 1'b0;
      case (state)
        S_WAIT: begin
          if (adc_valid) begin
            sample      <= adc_data;
            sample_zero <= 1'b0;
          end else if (wait_expired) begin
            sample_zero <= 1'b1;
          end
        end
        S_EVAL: begin
          gap_cnt <= GAP_W'(SAMPLE_INTERVAL - 1);
          cand    <= code_new;
          if (mode_chg) begin
            // New mode restarts filtering; this sample only seeds the candidate.
            mode_q   <= pickMode;
            stable   <= DB_W'(1);
            accepted <= '0;
            rep      <= '0;
            move_dir <= '0;
            lr_dir   <= '0;
          end else begin
            stable   <= stable_n;
            accepted <= acc_n;
            rep      <= rep_n;
            if (pulse) begin
              if (mode_q) begin
                lr_pulse <= 1'b1;
                lr_dir   <= acc_n;
              end else begin
                move_pulse <= 1'b1;
                move_dir   <= acc_n;
              end
            end
          end
        end
        S_GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef ADC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wait_cnt;
  logic            err_q;

  assign wait_expired = (state == S_WAIT) && !adc_valid && (wait_cnt == TO_W'(TIMEOUT - 1));
  assign adc_err      = err_q;

  always_ff @(posedge sys_clk) begin
    if (Reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else if (state == S_WAIT && !adc_valid) begin
      wait_cnt <= wait_cnt + 1'b1;
      if (wait_expired) err_q <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign wait_expired = 1'b0;
  assign adc_err      = 1'b0;
`endif

endmodule
